// File: rtl/add_pipe.sv
// Pipelined carry-lookahead adder/subtractor with RV64 word ops, NZCV-style
// flags, tag passthrough, valid/ready backpressure and flush.
// Stage k resolves bit slice [k*CHUNK +: CHUNK] from a registered carry-in;
// the operands ride along the pipe and finished low slices are held until the
// output register, so an accepted op leaves after WIDTH/CHUNK edges.

// One CHUNK-wide slice built from 4-bit CLA groups.
module add_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  localparam int NG = CHUNK / 4;

  logic [CHUNK-1:0] g, p, c;
  logic [NG:0]      gc;
  logic [NG-1:0]    gg, gp;

  assign g = a & b;
  assign p = a | b;

  // Group generate/propagate, group carries, then bit carries inside each group
  always_comb begin
    gc    = '0;
    gg    = '0;
    gp    = '0;
    c     = '0;
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
      c[4*j] = gc[j];
      for (int i = 1; i < 4; i++)
        c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
    end
  end

  assign sum  = a ^ b ^ c;
  assign cout = gc[NG];
endmodule

module add_pipe #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);
  localparam int LAT = WIDTH / CHUNK;
  localparam int H   = WIDTH / 2;
  localparam int HS  = LAT / 2;   // first slice of the upper half

  logic [LAT:0]                 vld_pipe;
  logic [LAT-1:0][WIDTH-1:0]    a_q, b_q, r_q, r_nx;
  logic [LAT-1:0]               c_q, cw_q, cw_nx, w_q;
  logic [LAT-1:0][TAG_W-1:0]    tag_q;
  logic [LAT-1:0][CHUNK-1:0]    sum_s;
  logic [LAT-1:0]               cout_s;
  logic                         stall, adv;

  // Whole pipe freezes while the output is held; flush always advances
  assign stall     = vld_pipe[LAT] & ~out_ready;
  assign adv       = ~stall | flush;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe[LAT];

  for (genvar k = 0; k < LAT; k++) begin : g_slice
    add_slice #(.CHUNK(CHUNK)) u_slice (
      .a   (a_q[k][k*CHUNK +: CHUNK]),
      .b   (b_q[k][k*CHUNK +: CHUNK]),
      .cin (c_q[k]),
      .sum (sum_s[k]),
      .cout(cout_s[k])
    );
  end

  // Merge each stage's slice into its partial result; latch the bit H-1 carry
  always_comb begin
    r_nx  = r_q;
    cw_nx = cw_q;
    for (int k = 0; k < LAT; k++) begin
      r_nx[k][k*CHUNK +: CHUNK] = sum_s[k];
      if (k == HS - 1) cw_nx[k] = cout_s[k];
    end
  end

  // Stage registers: stage 0 captures operands, later stages shift forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      cw_q     <= '0;
      w_q      <= '0;
      tag_q    <= '0;
    end else if (adv) begin
      vld_pipe <= flush ? '0 : {vld_pipe[LAT-1:0], in_valid};
      a_q[0]   <= in_a;
      b_q[0]   <= in_op[0] ? ~in_b : in_b;
      c_q[0]   <= in_op[0];
      r_q[0]   <= '0;
      cw_q[0]  <= 1'b0;
      w_q[0]   <= in_op[1];
      tag_q[0] <= in_tag;
      for (int k = 1; k < LAT; k++) begin
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        r_q[k]   <= r_nx[k-1];
        c_q[k]   <= cout_s[k-1];
        cw_q[k]  <= cw_nx[k-1];
        w_q[k]   <= w_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  logic [WIDTH-1:0] rf, res;
  logic             ovf, cry;
  logic [WIDTH-1:0] al, bl;

  assign rf = r_nx[LAT-1];
  assign al = a_q[LAT-1];
  assign bl = b_q[LAT-1];

  // Final result shaping: word ops sign-extend and take flags at bit H-1
  always_comb begin
    if (w_q[LAT-1]) begin
      res = {{H{rf[H-1]}}, rf[H-1:0]};
      cry = cw_nx[LAT-1];
      ovf = (al[H-1] == bl[H-1]) & (rf[H-1] != al[H-1]);
    end else begin
      res = rf;
      cry = cout_s[LAT-1];
      ovf = (al[WIDTH-1] == bl[WIDTH-1]) & (rf[WIDTH-1] != al[WIDTH-1]);
    end
  end

  // Output register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      out_zero   <= 1'b0;
      out_tag    <= '0;
    end else if (adv) begin
      out_result <= res;
      out_carry  <= cry;
      out_ovf    <= ovf;
      out_zero   <= (res == '0);
      out_tag    <= tag_q[LAT-1];
    end
  end
endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe (WIDTH=64, CHUNK=16): directed table,
// stall/flush/reset sequences and random traffic against an arithmetic model.
module tb_add_pipe;
  localparam int W = 64, H = 32, TW = 5, LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic          out_carry, out_ovf, out_zero;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a, in_b, out_result;
  logic [TW-1:0] in_tag, out_tag;

  add_pipe #(.WIDTH(W), .CHUNK(16), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic          c, v, z;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, res;
    logic         c, v, z;
  } vec_t;

  exp_t q[$];
  exp_t e_mon, hold;
  logic hold_v = 1'b0;
  int   n_chk = 0, n_fail = 0, n_out = 0;
  logic [TW-1:0] last_tag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: true signed/unsigned arithmetic on the selected width
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [TW-1:0] tag);
    exp_t e;
    logic signed [W+1:0] sx;
    logic signed [H+1:0] sw;
    logic [W:0]   u;
    logic [H:0]   uw;
    logic [H-1:0] aw, bw, rw;
    e.tag = tag;
    if (!op[1]) begin
      if (op[0]) begin
        sx = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        e.res = a - b;
        e.c = (a >= b);
      end else begin
        sx = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        u = {1'b0, a} + {1'b0, b};
        e.res = u[W-1:0];
        e.c = u[W];
      end
      e.v = (sx != $signed({{2{e.res[W-1]}}, e.res}));
    end else begin
      aw = a[H-1:0];
      bw = b[H-1:0];
      if (op[0]) begin
        sw = $signed({{2{aw[H-1]}}, aw}) - $signed({{2{bw[H-1]}}, bw});
        rw = aw - bw;
        e.c = (aw >= bw);
      end else begin
        sw = $signed({{2{aw[H-1]}}, aw}) + $signed({{2{bw[H-1]}}, bw});
        uw = {1'b0, aw} + {1'b0, bw};
        rw = uw[H-1:0];
        e.c = uw[H];
      end
      e.v = (sw != $signed({{2{rw[H-1]}}, rw}));
      e.res = {{H{rw[H-1]}}, rw};
    end
    e.z = (e.res == '0);
    return e;
  endfunction

  // Scoreboard: predicts the next edge from inputs/outputs sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
      if (hold_v) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_result", out_result, hold.res);
        chk("hold_flags", {56'd0, out_carry, out_ovf, out_zero, out_tag},
            {56'd0, hold.c, hold.v, hold.z, hold.tag});
      end
      hold_v = out_valid && !out_ready && !flush;
      hold.res = out_result; hold.c = out_carry; hold.v = out_ovf;
      hold.z = out_zero; hold.tag = out_tag;
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready) begin
          n_out++;
          last_tag = out_tag;
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_out: got tag %0d expected no output", out_tag);
          end else begin
            e_mon = q.pop_front();
            chk("result", out_result, e_mon.res);
            chk("flags_cvz", {61'd0, out_carry, out_ovf, out_zero}, {61'd0, e_mon.c, e_mon.v, e_mon.z});
            chk("tag", {59'd0, out_tag}, {59'd0, e_mon.tag});
          end
        end
        if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, in_tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '1;
      1: return '0;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {32'd0, 32'h7FFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  vec_t vt[10];
  int   cyc, sent, n0;
  logic acc;

  initial begin
    vt[0] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0, 1};
    vt[1] = '{2'b01, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0};
    vt[2] = '{2'b01, 64'd7, 64'd5, 64'd2, 1, 0, 0};
    vt[3] = '{2'b10, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 0, 1, 0};
    vt[4] = '{2'b11, 64'h1234_0000_0000_0001, 64'h1234_0000_0000_0001, 64'd0, 1, 0, 1};
    vt[5] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0, 1, 0};
    vt[6] = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0};
    vt[7] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0, 1};
    vt[8] = '{2'b01, 64'd0, 64'd0, 64'd0, 1, 0, 1};
    vt[9] = '{2'b11, 64'd0, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 0, 1, 0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_flags", {56'd0, out_carry, out_ovf, out_zero, out_tag}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed table, one op at a time, with latency measurement
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b; in_tag = TW'(i);
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin tick(); cyc++; end
      chk($sformatf("vec%0d_latency", i), 64'(cyc), 64'(LAT));
      chk($sformatf("vec%0d_result", i), out_result, vt[i].res);
      chk($sformatf("vec%0d_cvz", i), {61'd0, out_carry, out_ovf, out_zero},
          {61'd0, vt[i].c, vt[i].v, vt[i].z});
      tick();
    end

    // Back-to-back 8 ops with output stalled in cycles 5-7
    n0 = n_out; sent = 0;
    for (int c = 0; c < 25; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      in_valid = (sent < 8);
      in_op = 2'($urandom); in_a = rnd_val(); in_b = rnd_val(); in_tag = TW'(sent);
      #1;
      acc = in_valid && in_ready;
      if (c == 6) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("b2b_count", 64'(n_out - n0), 64'd8);

    // Flush with 3 ops in flight, then one op right after
    n0 = n_out;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 2'b00; in_a = 64'(i); in_b = 64'd100; in_tag = TW'(20 + i);
      tick();
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1; in_op = 2'b00; in_a = 64'd10; in_b = 64'd20; in_tag = 5'd31;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("flush_count", 64'(n_out - n0), 64'd1);
    chk("flush_tag", {59'd0, last_tag}, 64'd31);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 2'b01; in_a = 64'd3; in_b = 64'd9; in_tag = TW'(10 + i);
      tick();
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_flags", {56'd0, out_carry, out_ovf, out_zero, out_tag}, 64'd0);
    chk("midrst_result", out_result, 64'd0);
    tick();
    rst_n = 1'b1;
    n0 = n_out;
    repeat (8) tick();
    chk("midrst_no_stale", 64'(n_out - n0), 64'd0);

    // Random traffic with backpressure and occasional flush
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_op = 2'($urandom); in_a = rnd_val(); in_b = rnd_val(); in_tag = TW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 149) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 50) begin tick(); cyc++; end
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
